// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access sizes, FSM states and the
// registered data-memory request.
package mips_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extract/extend, and misalignment check.
// Size 2'b11 falls into the word case.
module lsu_align
   import mips_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wd,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misalign
);

   logic [31:0] shifted;

   always_comb begin
      shifted  = rdata >> {addr_lo, 3'b000};
      be       = 4'b1111;
      wdata    = wd;
      ldata    = shifted;
      misalign = 1'b0;
      case (size)
         SZ_B: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{wd[7:0]}};
            ldata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{wd[15:0]}};
            ldata    = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            misalign = addr_lo[0];
         end
         default: begin
            misalign = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs one req/ack data-memory access per load/store, stalling
// upstream and sending bubbles to MEMWB until the access completes.
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data,
   input  logic [4:0]  Dest,
   input  logic        RegWrite,
   input  logic        Jump,
   input  logic        MemtoReg,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] read_data,
   output logic [31:0] alu_result_out,
   output logic [4:0]  Dest_out,
   output logic        RegWrite_out,
   output logic        Jump_out,
   output logic        MemtoReg_out,
   output logic        stall,
   output logic        misalign_exc,
   output logic        bus_err
);

   state_t          state, state_nx;
   logic [TO_W-1:0] to_cnt;
   logic [31:0]     rdata_q;
   dmem_req_t       req_q;

   logic        mem_op, mis, to_hit;
   logic [3:0]  be;
   logic [31:0] wdata, ldata;

   assign mem_op = MemRead | MemWrite;

   lsu_align u_align (
      .addr_lo     (alu_result[1:0]),
      .size        (mem_size),
      .is_unsigned (mem_unsigned),
      .wd          (write_data),
      .rdata       (rdata_q),
      .be          (be),
      .wdata       (wdata),
      .ldata       (ldata),
      .misalign    (mis)
   );

   assign dmem_req   = (state == REQ);
   assign dmem_we    = req_q.we;
   assign dmem_addr  = req_q.addr;
   assign dmem_be    = req_q.be;
   assign dmem_wdata = req_q.wdata;

   // Last cycle allowed without ack; an ack in that same cycle still wins.
   assign to_hit = (state == REQ) && !dmem_ack && (to_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         to_cnt  <= '0;
         rdata_q <= '0;
         req_q   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && mem_op && !mis)
            req_q <= '{addr: {alu_result[31:2], 2'b00}, we: MemWrite, be: be, wdata: wdata};
         if (state == REQ && !dmem_ack)
            to_cnt <= to_cnt + 1'b1;
         else
            to_cnt <= '0;
         if (state == REQ && dmem_ack)
            rdata_q <= dmem_rdata;
      end
   end

   always_comb begin
      state_nx       = state;
      stall          = 1'b0;
      misalign_exc   = 1'b0;
      bus_err        = 1'b0;
      alu_result_out = alu_result;
      Dest_out       = Dest;
      MemtoReg_out   = MemtoReg;
      RegWrite_out   = RegWrite;
      Jump_out       = Jump;
      read_data      = '0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               RegWrite_out = 1'b0;
               Jump_out     = 1'b0;
               if (mis) begin
                  misalign_exc = 1'b1;
               end else begin
                  stall    = 1'b1;
                  state_nx = REQ;
               end
            end
         end
         REQ: begin
            RegWrite_out = 1'b0;
            Jump_out     = 1'b0;
            if (dmem_ack) begin
               stall    = 1'b1;
               state_nx = DONE;
            end else if (to_hit) begin
               bus_err  = 1'b1;
               state_nx = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         DONE: begin
            read_data = MemRead ? ldata : 32'h0;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit, built with TIMEOUT=4.
module tb_mem_access_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_result, write_data, dmem_rdata;
   logic [4:0]  Dest;
   logic        RegWrite, Jump, MemtoReg, MemRead, MemWrite, mem_unsigned, dmem_ack;
   logic [1:0]  mem_size;
   logic        dmem_req, dmem_we, RegWrite_out, Jump_out, MemtoReg_out;
   logic        stall, misalign_exc, bus_err;
   logic [31:0] dmem_addr, dmem_wdata, read_data, alu_result_out;
   logic [3:0]  dmem_be;
   logic [4:0]  Dest_out;

   int vectors = 0;
   int errs    = 0;
   int stalls;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst(rst), .alu_result(alu_result), .write_data(write_data),
      .Dest(Dest), .RegWrite(RegWrite), .Jump(Jump), .MemtoReg(MemtoReg),
      .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .read_data(read_data),
      .alu_result_out(alu_result_out), .Dest_out(Dest_out),
      .RegWrite_out(RegWrite_out), .Jump_out(Jump_out), .MemtoReg_out(MemtoReg_out),
      .stall(stall), .misalign_exc(misalign_exc), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, input logic [4:0] d);
      MemRead = rd; MemWrite = wr; mem_size = sz; mem_unsigned = uns;
      alu_result = a; write_data = wd; RegWrite = rw; Dest = d;
      Jump = 1'b0; MemtoReg = rd;
   endtask

   task automatic set_nop();
      set_op(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
   endtask

   // Load with ack in the first REQ cycle; returns with the DUT in DONE.
   task automatic quick_load(input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] rd);
      set_op(1'b1, 1'b0, sz, uns, a, 32'h0, 1'b1, 5'd3);
      tick();
      dmem_ack = 1'b1; dmem_rdata = rd;
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      #1;
   endtask

   initial begin
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      set_nop();
      tick(); tick();
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rw", RegWrite_out, 0);
      chk("rst_rdata", read_data, 0);
      rst = 1'b0;

      // 1: LW 0x100, ack in third REQ cycle
      set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 1'b1, 5'd5);
      #1;
      stalls = int'(stall);
      chk("lw_idle_bubble", RegWrite_out, 0);
      chk("lw_idle_noreq", dmem_req, 0);
      tick();
      stalls += int'(stall);
      chk("lw_req", dmem_req, 1);
      chk("lw_addr", dmem_addr, 32'h100);
      chk("lw_we", dmem_we, 0);
      chk("lw_be", dmem_be, 4'hF);
      chk("lw_req_bubble", RegWrite_out, 0);
      tick();
      stalls += int'(stall);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      stalls += int'(stall);
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      #1;
      chk("lw_stall_cycles", stalls, 4);
      chk("lw_done_stall", stall, 0);
      chk("lw_done_rdata", read_data, 32'hDEADBEEF);
      chk("lw_done_rw", RegWrite_out, 1);
      chk("lw_done_dest", Dest_out, 5);
      chk("lw_done_noreq", dmem_req, 0);
      set_nop();
      tick();
      chk("lw_after_rw", RegWrite_out, 0);
      chk("lw_after_rdata", read_data, 0);

      // 2: SB 0x203
      set_op(1'b0, 1'b1, SZ_B, 1'b0, 32'h203, 32'h000000A5, 1'b0, 5'd0);
      #1;
      chk("sb_idle_stall", stall, 1);
      tick();
      chk("sb_addr", dmem_addr, 32'h200);
      chk("sb_be", dmem_be, 4'b1000);
      chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
      chk("sb_we", dmem_we, 1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("sb_done_stall", stall, 0);
      chk("sb_done_rw", RegWrite_out, 0);
      set_nop();
      tick();

      // 3: sub-word loads at byte offset 2
      quick_load(SZ_B, 1'b0, 32'h2, 32'h0080FF00);
      chk("lb_sext", read_data, 32'hFFFFFF80);
      set_nop(); tick();
      quick_load(SZ_B, 1'b1, 32'h2, 32'h0080FF00);
      chk("lbu_zext", read_data, 32'h00000080);
      set_nop(); tick();
      quick_load(SZ_H, 1'b0, 32'h2, 32'h0080FF00);
      chk("lh_sext", read_data, 32'h00000080);
      set_nop(); tick();
      quick_load(SZ_H, 1'b0, 32'h0, 32'h0000FF00);
      chk("lh_neg", read_data, 32'hFFFFFF00);
      set_nop(); tick();

      // 4: misaligned word load and half store
      set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 1'b1, 5'd9);
      #1;
      chk("lw_mis_exc", misalign_exc, 1);
      chk("lw_mis_stall", stall, 0);
      chk("lw_mis_rw", RegWrite_out, 0);
      set_nop();
      tick();
      chk("lw_mis_noreq", dmem_req, 0);
      chk("lw_mis_pulse", misalign_exc, 0);
      set_op(1'b0, 1'b1, SZ_H, 1'b0, 32'h101, 32'h1234, 1'b0, 5'd0);
      #1;
      chk("sh_mis_exc", misalign_exc, 1);
      chk("sh_mis_stall", stall, 0);
      set_nop();
      tick();
      chk("sh_mis_noreq", dmem_req, 0);

      // 5: ack never arrives
      set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h300, 32'h0, 1'b1, 5'd4);
      tick();
      chk("to_req1", dmem_req, 1);
      chk("to_noerr1", bus_err, 0);
      tick(); tick();
      chk("to_noerr3", bus_err, 0);
      chk("to_stall3", stall, 1);
      tick();
      chk("to_err4", bus_err, 1);
      chk("to_stall4", stall, 0);
      chk("to_rw4", RegWrite_out, 0);
      set_nop();
      tick();
      chk("to_idle_req", dmem_req, 0);
      chk("to_idle_err", bus_err, 0);

      // 6: reset in second REQ cycle, ack afterwards
      set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h400, 32'h0, 1'b1, 5'd6);
      tick();
      tick();
      chk("rr_req2", dmem_req, 1);
      rst = 1'b1;
      tick();
      chk("rr_req_drop", dmem_req, 0);
      chk("rr_rw", RegWrite_out, 0);
      rst = 1'b0;
      set_op(1'b0, 1'b0, SZ_W, 1'b0, 32'h12345678, 32'h0, 1'b1, 5'd7);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
      #1;
      chk("alu_pass_val", alu_result_out, 32'h12345678);
      chk("alu_pass_dest", Dest_out, 7);
      chk("alu_pass_rw", RegWrite_out, 1);
      chk("alu_pass_stall", stall, 0);
      chk("alu_pass_rdata", read_data, 0);
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("late_ack_req", dmem_req, 0);
      chk("late_ack_stall", stall, 0);
      chk("late_ack_rdata", read_data, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
